// File: rtl/escaner_teclado_pkg.sv
// rtl/escaner_teclado_pkg.sv - shared FSM states and 4x4 keypad code map
package escaner_teclado_pkg;

  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    DEBOUNCE     = 2'd1,
    EMIT         = 2'd2,
    WAIT_RELEASE = 2'd3
  } estado_e;

  // Nibble {fila,col} holds the code: r0 1 2 3 A, r1 4 5 6 B, r2 7 8 9 C, r3 E(*) 0 F(#) D
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

  function automatic logic [3:0] key_code(input logic [1:0] fila, input logic [1:0] col);
    logic [5:0] base;
    base = {fila, col, 2'b00};
    return KEY_MAP[base +: 4];
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// rtl/sincronizador_2ff.sv - two-flop synchronizer for asynchronous inputs
module sincronizador_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/escaner_teclado.sv
// rtl/escaner_teclado.sv - 4x4 keypad scanner with debounce, one pulse per accepted key
module escaner_teclado
  import escaner_teclado_pkg::*;
#(
  parameter int SCAN_TICKS     = 1000,
  parameter int DEBOUNCE_TICKS = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] filas,
  output logic [3:0] columnas,
  output logic [3:0] tecla_4bits,
  output logic       tecla_valida
);

  localparam int CW = $clog2(SCAN_TICKS);
  localparam int DW = $clog2(DEBOUNCE_TICKS);

  estado_e       state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    fila_q, fila_d;
  logic [CW-1:0] scan_cnt_q, scan_cnt_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]    tecla_q, tecla_d;
  logic [3:0]    filas_s;
  logic [1:0]    fila_baja_idx;
  logic          alguna_baja;
  logic          muestra_valida;
  logic          fila_baja;
  logic          deb_fin;

  sincronizador_2ff #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (filas),
    .q_o   (filas_s)
  );

  // Descending loop so the lowest low row is the last assignment and wins
  always_comb begin
    fila_baja_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!filas_s[i]) fila_baja_idx = 2'(i);
    end
  end

  // Synchronized rows reflect the current column only from its third cycle on
  assign muestra_valida = (scan_cnt_q >= CW'(2));
  assign alguna_baja    = ~&filas_s;
  assign fila_baja      = ~filas_s[fila_q];
  assign deb_fin        = (deb_cnt_q == DW'(DEBOUNCE_TICKS - 1));

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    fila_d     = fila_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    tecla_d    = tecla_q;
    case (state_q)
      SCAN: begin
        if (muestra_valida && alguna_baja) begin
          state_d   = DEBOUNCE;
          fila_d    = fila_baja_idx;
          deb_cnt_d = '0;
        end else if (scan_cnt_q == CW'(SCAN_TICKS - 1)) begin
          scan_cnt_d = '0;
          col_d      = col_q + 2'd1;
        end else begin
          scan_cnt_d = scan_cnt_q + CW'(1);
        end
      end
      DEBOUNCE: begin
        if (!fila_baja) begin
          state_d    = SCAN;
          col_d      = col_q + 2'd1;
          scan_cnt_d = '0;
          deb_cnt_d  = '0;
        end else if (deb_fin) begin
          state_d = EMIT;
          tecla_d = key_code(fila_q, col_q);
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
      EMIT: begin
        state_d   = WAIT_RELEASE;
        deb_cnt_d = '0;
      end
      WAIT_RELEASE: begin
        if (fila_baja) begin
          deb_cnt_d = '0;
        end else if (deb_fin) begin
          state_d    = SCAN;
          col_d      = col_q + 2'd1;
          scan_cnt_d = '0;
          deb_cnt_d  = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SCAN;
      col_q      <= 2'd0;
      fila_q     <= 2'd0;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      tecla_q    <= 4'h0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      fila_q     <= fila_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      tecla_q    <= tecla_d;
    end
  end

  assign columnas     = ~(4'b0001 << col_q);
  assign tecla_4bits  = tecla_q;
  assign tecla_valida = (state_q == EMIT);

endmodule

// File: tb/tb_escaner_teclado.sv
// tb/tb_escaner_teclado.sv - directed bench for escaner_teclado with a keypad matrix model
module tb_escaner_teclado;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  filas;
  logic [3:0]  columnas;
  logic [3:0]  tecla_4bits;
  logic        tecla_valida;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int pulse_cyc = 0;
  int col_err = 0;
  logic [3:0] pulse_code = 4'h0;

  always #5 clk = ~clk;

  escaner_teclado #(.SCAN_TICKS(4), .DEBOUNCE_TICKS(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .filas        (filas),
    .columnas     (columnas),
    .tecla_4bits  (tecla_4bits),
    .tecla_valida (tecla_valida)
  );

  // Key at (r,c), index r*4+c, pulls row r low while column c is driven low
  always_comb begin
    filas = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !columnas[c]) filas[r] = 1'b0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (tecla_valida) begin
        pulse_cnt  <= pulse_cnt + 1;
        pulse_code <= tecla_4bits;
        pulse_cyc  <= cyc;
      end
      if ($countones(columnas) != 3) col_err <= col_err + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cols(input logic [3:0] pat, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (columnas == pat) found = 1'b1;
      else @(negedge clk);
    end
    check(tag, 32'(found), 32'd1);
  endtask

  initial begin
    int p0;
    int tlow;
    logic got;
    logic [3:0] exp_col;

    rst_n = 1'b0;
    keys  = 16'h0;
    tick(3);
    check("rst_columnas", 32'(columnas), 32'hE);
    check("rst_tecla", 32'(tecla_4bits), 32'h0);
    check("rst_valida", 32'(tecla_valida), 32'h0);
    rst_n = 1'b1;

    for (int k = 0; k < 64; k++) begin
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      check("scan_col", 32'(columnas), 32'(exp_col));
      @(negedge clk);
    end
    check("idle_pulses", 32'(pulse_cnt), 32'd0);

    p0 = pulse_cnt;
    got = 1'b0;
    tlow = 0;
    keys[6] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!got && !filas[1]) begin
        got = 1'b1;
        tlow = cyc;
      end
    end
    keys = 16'h0;
    tick(20);
    check("k6_row_low", 32'(got), 32'd1);
    check("k6_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("k6_code", 32'(pulse_code), 32'h6);
    check("k6_held", 32'(tecla_4bits), 32'h6);
    check("k6_latency", 32'((pulse_cyc - tlow) <= 11), 32'd1);

    p0 = pulse_cnt;
    wait_cols(4'b0111, "bounce_sync_c3");
    wait_cols(4'b1110, "bounce_sync_c0");
    keys[12] = 1'b1; tick(1);
    keys[12] = 1'b0; tick(1);
    keys[12] = 1'b1; tick(1);
    keys[12] = 1'b0;
    tick(40);
    check("bounce_only", 32'(pulse_cnt - p0), 32'd0);
    wait_cols(4'b0111, "bounce2_sync_c3");
    wait_cols(4'b1110, "bounce2_sync_c0");
    keys[12] = 1'b1; tick(1);
    keys[12] = 1'b0; tick(1);
    keys[12] = 1'b1;
    tick(60);
    keys = 16'h0;
    tick(30);
    check("kE_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("kE_code", 32'(tecla_4bits), 32'hE);

    p0 = pulse_cnt;
    keys[5] = 1'b1;
    tick(40);
    check("k5_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("k5_code", 32'(tecla_4bits), 32'h5);
    keys = 16'h0;
    tick(4);
    keys[5] = 1'b1;
    tick(30);
    check("k5_no_repeat", 32'(pulse_cnt - p0), 32'd1);
    keys = 16'h0;
    tick(12);
    keys[13] = 1'b1;
    tick(40);
    keys = 16'h0;
    tick(30);
    check("k0_pulses", 32'(pulse_cnt - p0), 32'd2);
    check("k0_code", 32'(tecla_4bits), 32'h0);

    p0 = pulse_cnt;
    keys[3]  = 1'b1;
    keys[11] = 1'b1;
    tick(40);
    keys = 16'h0;
    tick(30);
    check("multi_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("multi_code", 32'(tecla_4bits), 32'hA);

    p0 = pulse_cnt;
    got = 1'b0;
    keys[10] = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (!filas[2]) got = 1'b1;
    end
    check("k9_row_low", 32'(got), 32'd1);
    tick(4);
    check("k9_pre_reset_pulses", 32'(pulse_cnt - p0), 32'd0);
    check("k9_pre_reset_held", 32'(tecla_4bits), 32'hA);
    rst_n = 1'b0;
    #1;
    check("k9_rst_columnas", 32'(columnas), 32'hE);
    check("k9_rst_tecla", 32'(tecla_4bits), 32'h0);
    check("k9_rst_valida", 32'(tecla_valida), 32'h0);
    tick(3);
    rst_n = 1'b1;
    tick(60);
    check("k9_pulses", 32'(pulse_cnt - p0), 32'd1);
    check("k9_code", 32'(pulse_code), 32'h9);
    keys = 16'h0;
    tick(30);
    check("k9_after_release", 32'(pulse_cnt - p0), 32'd1);

    check("col_onehot", 32'(col_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/escaner_teclado.md
ESCANER_TECLADO -- requirements
Module: escaner_teclado

Interface
REQ-001 Parameter SCAN_TICKS, default 1000: clock cycles each column stays driven while scanning (min 4).
REQ-002 Parameter DEBOUNCE_TICKS, default 20000: consecutive stable cycles to accept a press or a release (min 2).
REQ-003 clk  input  1  single system clock; all logic rises on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 filas  input  4  keypad row lines, active-low (external pull-ups), asynchronous to clk.
REQ-006 columnas  output  4  keypad column drive, active-low, exactly one bit low at any time.
REQ-007 tecla_4bits  output  4  code of the last accepted key, held until the next acceptance; feeds the ASCII converter directly.
REQ-008 tecla_valida  output  1  one-cycle pulse marking a new accepted key.

Function
REQ-009 filas SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-010 FSM states SHALL be SCAN, DEBOUNCE, EMIT, WAIT_RELEASE.
REQ-011 SCAN: columnas rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing after SCAN_TICKS cycles per column; a row sample is valid only after the column has been driven at least 3 cycles (settling plus synchronizer).
REQ-012 SCAN -> DEBOUNCE when any valid synchronized row reads low; latch column index and row index; with multiple rows low, the lowest row index wins.
REQ-013 DEBOUNCE: column frozen; counter increments each cycle the latched row is low; the latched row going high returns to SCAN at the next column with counter cleared.
REQ-014 DEBOUNCE -> EMIT when the counter reaches DEBOUNCE_TICKS-1; EMIT lasts one cycle, loads tecla_4bits and asserts tecla_valida in that cycle.
REQ-015 EMIT -> WAIT_RELEASE; no further pulse while the key is held (no auto-repeat).
REQ-016 WAIT_RELEASE: column frozen; counter counts consecutive cycles with latched row high, cleared on any low; reaching DEBOUNCE_TICKS-1 returns to SCAN at the next column.
REQ-017 Key map (row,col -> code): r0: 1,2,3,A; r1: 4,5,6,B; r2: 7,8,9,C; r3: E(*),0,F(#),D; digits map to 4'h0-4'h9.
REQ-018 Keys in other columns pressed during DEBOUNCE/WAIT_RELEASE SHALL be ignored.
REQ-019 Counters SHALL be sized by $clog2 of their parameter and never wrap; the counter holds at terminal value until the state changes.

Reset
REQ-020 On rst_n low: state SCAN, columnas 4'b1110, tecla_4bits 4'h0, tecla_valida 0, counters and synchronizer flops cleared.
REQ-021 Reset asserted mid-debounce or mid-hold SHALL discard the pending key; no pulse is issued for it after reset release.
REQ-022 A key held across reset release SHALL be re-detected and emitted once after full debounce.

Structure
REQ-023 Shared package holds the state enumeration and the 16-entry key-code map constants.
REQ-024 One sub-module, sincronizador_2ff (4-bit, parameterized width), is natural; the rest is a single module.

Verification (SCAN_TICKS=4, DEBOUNCE_TICKS=8)
REQ-025 Idle, filas=1111 for 64 cycles -> columnas cycles 1110,1101,1011,0111 every 4 cycles; tecla_valida never 1.
REQ-026 Row 1 low while column 2 driven, held 40 cycles -> exactly one tecla_valida pulse, tecla_4bits=4'h6, pulse within 2+8+1 cycles of assertion.
REQ-027 Row 3 low on column 0 with 3-cycle bounce (low/high toggling) then stable -> single pulse, code 4'hE; bounce alone produces none.
REQ-028 Press '5', release for 4 cycles, re-press -> one pulse only; release for 12 cycles then press '0' -> second pulse, code 4'h0.
REQ-029 rst_n low during DEBOUNCE of '9' -> outputs at reset values immediately; after release with key still held, one pulse code 4'h9.
REQ-030 Rows 0 and 2 low together on column 3 -> one pulse, code 4'hA.
